rr_grant_encoder: RTL and testbench

- Sequential counterpart to the register-file write decoder: takes up to N one-hot-style request lines and produces a single held grant.
- Each grant is reported both one-hot and binary-encoded, so one of eight sources can drive a register-file write port through the Mux8/Decoder path.
- Arbitration is round-robin.
- A granted source keeps ownership until it releases.

---
 rtl/rr_grant_encoder.sv | 90 +++++++++
 tb/tb_rr_grant_encoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter that holds a single grant until its owner releases it.
// Every grant is reported both one-hot and as a binary index.
module rr_grant_encoder #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    logic            state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;

    logic [IDXW-1:0] winIdx;
    logic            winFound;
    logic [IDXW-1:0] cand;

    // Circular scan from ptr upward; the IDXW-bit sum wraps naturally mod N.
    always_comb begin
        winIdx   = '0;
        winFound = 1'b0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + IDXW'(k);
            if (!winFound && req[cand]) begin
                winIdx   = cand;
                winFound = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        case (state_q)
            STATE_IDLE: begin
                if (winFound) begin
                    grant_d = N'(1) << winIdx;
                    idx_d   = winIdx;
                    valid_d = 1'b1;
                    state_d = STATE_BUSY;
                end
            end
            default: begin
                // The index is kept on release so it stays stable while idle.
                if (done || !req[idx_q]) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + IDXW'(1);
                    state_d = STATE_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STATE_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Self-checking bench for rr_grant_encoder: vector table plus scoreboard queue,
// with hand-written sequences for round-robin wrap and asynchronous reset.
module tb_rr_grant_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;

    int nCompared;
    int nFailed;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] expGrant;
        logic [2:0] expIdx;
        logic       expValid;
    } vec_t;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    rr_grant_encoder #(.N(8), .IDXW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Structural invariants, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            nCompared++;
            if ((grant & (grant - 8'd1)) != 8'd0 || grant_valid != (|grant) ||
                (grant_valid && grant != (8'd1 << grant_idx))) begin
                nFailed++;
                $display("[TB] FAIL invariant: grant=%b idx=%0d valid=%b", grant, grant_idx, grant_valid);
            end
        end
    end

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            nCompared++;
            nFailed++;
            $display("[TB] FAIL scoreboard: empty queue when output expected");
            return;
        end
        e = sb.pop_front();
        nCompared++;
        if (grant !== e.grant || grant_idx !== e.idx || grant_valid !== e.valid) begin
            nFailed++;
            $display("[TB] FAIL %s: got grant=%b idx=%0d valid=%b, expected grant=%b idx=%0d valid=%b",
                     e.name, grant, grant_idx, grant_valid, e.grant, e.idx, e.valid);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
    task automatic applyStimulus(input logic [7:0] r, input logic d, input logic [7:0] eg,
                                 input logic [2:0] ei, input logic ev, input string name);
        exp_t e;
        req  = r;
        done = d;
        e.grant = eg;
        e.idx   = ei;
        e.valid = ev;
        e.name  = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        nCompared++;
        if (grant !== 8'd0 || grant_idx !== 3'd0 || grant_valid !== 1'b0) begin
            nFailed++;
            $display("[TB] FAIL reset_state: got grant=%b idx=%0d valid=%b, expected all zero",
                     grant, grant_idx, grant_valid);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nCompared = 0;
        nFailed   = 0;
        reset = 1'b1;
        req   = 8'hFF;
        done  = 1'b0;

        // Hold, no preemption, release by done, release by req drop, idle done.
        vecs.push_back('{8'h04, 1'b0, 8'h04, 3'd2, 1'b1});
        for (int i = 0; i < 5; i++) vecs.push_back('{8'h85, 1'b0, 8'h04, 3'd2, 1'b1});
        vecs.push_back('{8'h85, 1'b1, 8'h00, 3'd2, 1'b0});
        vecs.push_back('{8'h85, 1'b0, 8'h80, 3'd7, 1'b1});
        vecs.push_back('{8'h85, 1'b1, 8'h00, 3'd7, 1'b0});
        vecs.push_back('{8'h20, 1'b0, 8'h20, 3'd5, 1'b1});
        vecs.push_back('{8'h03, 1'b0, 8'h00, 3'd5, 1'b0});
        vecs.push_back('{8'h03, 1'b0, 8'h01, 3'd0, 1'b1});
        vecs.push_back('{8'h03, 1'b1, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{8'h02, 1'b0, 8'h02, 3'd1, 1'b1});
        vecs.push_back('{8'h00, 1'b1, 8'h00, 3'd1, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 8'h00, 3'd1, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 8'h00, 3'd1, 1'b0});
        vecs.push_back('{8'hFF, 1'b0, 8'h04, 3'd2, 1'b1});

        #12;
        nCompared++;
        if (grant !== 8'd0 || grant_idx !== 3'd0 || grant_valid !== 1'b0) begin
            nFailed++;
            $display("[TB] FAIL reset_hold: got grant=%b idx=%0d valid=%b, expected all zero",
                     grant, grant_idx, grant_valid);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        req   = 8'h00;
        @(posedge clk);
        #1;

        $display("[TB] table vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].done, vecs[i].expGrant, vecs[i].expIdx,
                          vecs[i].expValid, $sformatf("vec%0d", i));
        end

        $display("[TB] round-robin wrap");
        req  = 8'h00;
        done = 1'b0;
        doReset();
        applyStimulus(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, "rr_first");
        for (int k = 0; k < 8; k++) begin
            logic [2:0] nxt;
            nxt = 3'(k + 1);
            applyStimulus(8'hFF, 1'b1, 8'h00, 3'(k), 1'b0, $sformatf("rr_release%0d", k));
            applyStimulus(8'hFF, 1'b0, 8'd1 << nxt, nxt, 1'b1, $sformatf("rr_grant%0d", k + 1));
        end

        $display("[TB] async reset mid-grant");
        req  = 8'h00;
        done = 1'b0;
        doReset();
        applyStimulus(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, "owner3");
        applyStimulus(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, "owner3_hold");
        #3;
        reset = 1'b1;
        #1;
        nCompared++;
        if (grant !== 8'd0 || grant_valid !== 1'b0) begin
            nFailed++;
            $display("[TB] FAIL async_reset: got grant=%b valid=%b, expected grant=0 valid=0",
                     grant, grant_valid);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        req   = 8'h00;
        @(posedge clk);
        #1;
        applyStimulus(8'h09, 1'b0, 8'h01, 3'd0, 1'b1, "post_reset_ptr0");

        if (sb.size() != 0) begin
            nCompared++;
            nFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
